// File: rtl/fetch_stage_pkg.sv
// Shared decode definitions: RV32 base opcodes, fetch FSM states and the NOP word.
package fetch_stage_pkg;

  typedef enum logic [6:0] {
    I_TYPE  = 7'b0010011,
    I_LOAD  = 7'b0000011,
    I_JALR  = 7'b1100111,
    S_TYPE  = 7'b0100011,
    B_TYPE  = 7'b1100011,
    U_LUI   = 7'b0110111,
    U_AUIPC = 7'b0010111,
    J_TYPE  = 7'b1101111
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DRAIN
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_stage_instr_field_slice.sv
// Combinational extraction of opcode/func3 and the raw immediate bit fields;
// fields an opcode does not define read as zero.
module instr_field_slice
  import fetch_stage_pkg::*;
(
  input  logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic [11:0] imm,
  output logic [19:0] imm_u
);

  assign opcode = instr[6:0];
  assign func3  = instr[14:12];

  always_comb begin
    imm   = '0;
    imm_u = '0;
    case (instr[6:0])
      I_TYPE, I_LOAD, I_JALR: imm   = instr[31:20];
      S_TYPE:                 imm   = {instr[31:25], instr[11:7]};
      B_TYPE:                 imm   = {instr[31], instr[7], instr[30:25], instr[11:8]};
      U_LUI, U_AUIPC:         imm_u = instr[31:12];
      J_TYPE:                 imm_u = {instr[31], instr[19:12], instr[20], instr[30:21]};
      default: begin
        imm   = '0;
        imm_u = '0;
      end
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with single-outstanding imem requests, 1-entry skid buffer
// for decode stalls, redirect flush/drain, and the IF/ID register with pre-sliced fields.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall_id,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_instr,
  output logic [6:0]      id_opcode,
  output logic [2:0]      id_func3,
  output logic [11:0]     id_imm,
  output logic [19:0]     id_imm_u
);

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic            skid_valid;
  logic [XLEN-1:0] skid_pc;
  logic [31:0]     skid_instr;

  logic            accept_id;
  logic            req_fire;
  logic            resp_ok;
  logic [31:0]     next_instr;
  logic [6:0]      next_opcode;
  logic [2:0]      next_func3;
  logic [11:0]     next_imm;
  logic [19:0]     next_imm_u;

  assign accept_id = !id_valid || !stall_id;
  assign imem_req  = !rst && !redirect_valid && !skid_valid &&
                     (state == IDLE || (state == WAIT && imem_rvalid && accept_id));
  assign imem_addr = pc;
  assign req_fire  = imem_req && imem_ready;
  assign resp_ok   = (state == WAIT) && imem_rvalid;

  // Skid and a live response never coexist, so skid_valid alone picks the source.
  assign next_instr = skid_valid ? skid_instr : imem_rdata;

  instr_field_slice u_slice (
    .instr  (next_instr),
    .opcode (next_opcode),
    .func3  (next_func3),
    .imm    (next_imm),
    .imm_u  (next_imm_u)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      req_pc     <= RESET_PC;
      skid_valid <= 1'b0;
      skid_pc    <= RESET_PC;
      skid_instr <= NOP_INSTR;
      id_valid   <= 1'b0;
      id_pc      <= RESET_PC;
      id_instr   <= NOP_INSTR;
      id_opcode  <= NOP_INSTR[6:0];
      id_func3   <= NOP_INSTR[14:12];
      id_imm     <= NOP_INSTR[31:20];
      id_imm_u   <= '0;
    end else if (redirect_valid) begin
      // An in-flight response with no rvalid yet must be drained later.
      id_valid   <= 1'b0;
      skid_valid <= 1'b0;
      pc         <= redirect_pc;
      state      <= (state != IDLE && !imem_rvalid) ? DRAIN : IDLE;
    end else begin
      if (req_fire) begin
        req_pc <= pc;
        pc     <= pc + XLEN'(4);
      end

      case (state)
        IDLE:    if (req_fire) state <= WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            state <= req_fire ? WAIT : IDLE;
            if (!accept_id) begin
              skid_valid <= 1'b1;
              skid_pc    <= req_pc;
              skid_instr <= imem_rdata;
            end
          end
        end
        DRAIN:   if (imem_rvalid) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (accept_id) begin
        if (skid_valid || resp_ok) begin
          id_valid   <= 1'b1;
          id_pc      <= skid_valid ? skid_pc : req_pc;
          id_instr   <= next_instr;
          id_opcode  <= next_opcode;
          id_func3   <= next_func3;
          id_imm     <= next_imm;
          id_imm_u   <= next_imm_u;
          skid_valid <= 1'b0;
        end else begin
          id_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, streaming, stall/skid, redirects, field slicing.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall_id;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [6:0]  id_opcode;
  logic [2:0]  id_func3;
  logic [11:0] id_imm;
  logic [19:0] id_imm_u;

  int n_chk = 0;
  int n_err = 0;
  int lat   = 1;

  always #5 clk = ~clk;

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall_id       (stall_id),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_instr       (id_instr),
    .id_opcode      (id_opcode),
    .id_func3       (id_func3),
    .id_imm         (id_imm),
    .id_imm_u       (id_imm_u)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Default words are addi x0,x0,<addr[11:0]> so id_imm echoes the fetch address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h200: mem_word = 32'h00512423;
      32'h204: mem_word = 32'hFE000EE3;
      32'h208: mem_word = 32'h010000EF;
      32'h20C: mem_word = 32'h123452B7;
      default: mem_word = {a[11:0], 20'h00013};
    endcase
  endfunction

  // Memory: samples the request late in the low phase, responds lat cycles after acceptance.
  initial begin
    logic        fire;
    logic [31:0] addr_s;
    logic [31:0] paddr;
    int          cnt;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    cnt   = 0;
    paddr = '0;
    forever begin
      @(negedge clk);
      #3;
      fire   = imem_req && imem_ready;
      addr_s = imem_addr;
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (fire) begin
        cnt   = lat;
        paddr = addr_s;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(paddr);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; imem_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; stall_id = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_id_instr", id_instr, 32'h13);
    check("rst_id_pc", id_pc, 32'h0);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    rst = 1'b0;
    #1;
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'h0);
    @(negedge clk);
    check("b2b_addr", imem_addr, 32'h4);

    // Streaming at one instruction per cycle.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("stream_valid", 32'(id_valid), 32'd1);
      check("stream_pc", id_pc, 32'(4 * k));
      check("stream_imm", 32'(id_imm), 32'(4 * k));
      check("stream_addr", imem_addr, 32'(4 * k + 8));
    end

    // Stall while the response for 0x10 arrives: it must land in the skid.
    stall_id = 1'b1;
    #1;
    check("stall_req_off", 32'(imem_req), 32'd0);
    @(negedge clk);
    check("stall_hold_pc", id_pc, 32'hC);
    check("stall_hold_valid", 32'(id_valid), 32'd1);
    check("skid_blocks_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    check("stall_hold_pc2", id_pc, 32'hC);
    stall_id = 1'b0;
    @(negedge clk);
    check("skid_to_id_pc", id_pc, 32'h10);
    check("skid_to_id_instr", id_instr, mem_word(32'h10));
    check("resume_req", 32'(imem_req), 32'd1);
    check("resume_addr", imem_addr, 32'h14);
    @(negedge clk);
    check("bubble", 32'(id_valid), 32'd0);
    @(negedge clk);
    check("after_skid_pc", id_pc, 32'h14);
    check("after_skid_valid", 32'(id_valid), 32'd1);

    // Redirect coincident with the response for 0x18.
    check("coinc_rvalid", 32'(imem_rvalid), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    #1;
    check("redir_no_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("redir_flush", 32'(id_valid), 32'd0);
    check("redir_req", 32'(imem_req), 32'd1);
    check("redir_addr", imem_addr, 32'h100);
    lat = 3;

    // Redirect while a slow request is outstanding: its response must be drained.
    @(negedge clk);
    check("wait_no_req", 32'(imem_req), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("drain_no_req", 32'(imem_req), 32'd0);
    check("drain_id_valid", 32'(id_valid), 32'd0);
    @(negedge clk);
    check("stale_rvalid", 32'(imem_rvalid), 32'd1);
    check("drain_no_req2", 32'(imem_req), 32'd0);
    @(negedge clk);
    check("stale_dropped", 32'(id_valid), 32'd0);
    check("post_drain_req", 32'(imem_req), 32'd1);
    check("post_drain_addr", imem_addr, 32'h200);
    lat = 1;
    @(negedge clk);
    check("pre_slice_bubble", 32'(id_valid), 32'd0);

    // Field slicing on the redirected stream.
    @(negedge clk);
    check("sw_pc", id_pc, 32'h200);
    check("sw_opcode", 32'(id_opcode), 32'h23);
    check("sw_func3", 32'(id_func3), 32'd2);
    check("sw_imm", 32'(id_imm), 32'h008);
    check("sw_imm_u", 32'(id_imm_u), 32'h0);
    @(negedge clk);
    check("beq_pc", id_pc, 32'h204);
    check("beq_imm", 32'(id_imm), 32'hFFE);
    @(negedge clk);
    check("jal_pc", id_pc, 32'h208);
    check("jal_imm_u", 32'(id_imm_u), 32'h00008);
    check("jal_imm", 32'(id_imm), 32'h0);
    @(negedge clk);
    check("lui_pc", id_pc, 32'h20C);
    check("lui_imm_u", 32'(id_imm_u), 32'h12345);
    check("lui_valid", 32'(id_valid), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
